counter_rr_sched: RTL and testbench

- Round-robin scheduler that shares one WIDTH-bit up-counting resource between NREQ requesters.
- A granted requester owns the counter for one run, counting 0 up to its own terminal count under a global enable.
- The block then signals completion, releases the counter and re-arbitrates.
- Sits between the requesting control blocks and the shared counter datapath; it replaces per-requester counters.

---
 rtl/counter_rr_sched_if.sv | 29 ++
 rtl/counter_rr_sched.sv | 130 +++++++++++++
 tb/tb_counter_rr_sched.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_rr_sched_if.sv
// Bundle of request/terminal-count inputs and grant/counter outputs for the
// round-robin shared-counter scheduler.
interface counter_rr_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int OWNW  = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] tc;
  logic                  en;
  logic [NREQ-1:0]       gnt;
  logic [OWNW-1:0]       owner;
  logic [WIDTH-1:0]      cnt;
  logic                  busy;
  logic                  done;
  logic                  abort;

  // Requester side: drives requests, terminal counts and enable.
  modport master (
    output req, tc, en,
    input  gnt, owner, cnt, busy, done, abort
  );

  // Scheduler side.
  modport slave (
    input  req, tc, en,
    output gnt, owner, cnt, busy, done, abort
  );
endinterface

// File: rtl/counter_rr_sched.sv
// Round-robin scheduler sharing one up-counter between NREQ requesters.
// A grantee owns the counter for one run (0..its terminal count), then the
// block pulses done (or abort if the owner drops req) and re-arbitrates.
module counter_rr_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int OWNW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  counter_rr_sched_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q,   gnt_d;
  logic [OWNW-1:0]   owner_q, owner_d;
  logic [WIDTH-1:0]  cnt_q,   cnt_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              abort_q, abort_d;
  logic [OWNW-1:0]   ptr_q,   ptr_d;
  logic [WIDTH-1:0]  tcl_q,   tcl_d;

  logic              found;
  logic [OWNW-1:0]   win;
  logic [OWNW-1:0]   idx;
  logic [OWNW-1:0]   owner_nxt;

  // Winner search: first requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = OWNW'((32'(ptr_q) + i) % NREQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Pointer value after the current owner releases the counter.
  always_comb begin
    if (owner_q == OWNW'(NREQ - 1)) owner_nxt = '0;
    else                            owner_nxt = owner_q + 1'b1;
  end

  // Next-state and output decode; abort outranks completion.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    ptr_d   = ptr_q;
    tcl_d   = tcl_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          owner_d    = win;
          tcl_d      = bus.tc[int'(win)*WIDTH +: WIDTH];
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (!bus.req[owner_q]) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          abort_d = 1'b1;
          ptr_d   = owner_nxt;
          state_d = IDLE;
        end else if (bus.en) begin
          if (cnt_q == tcl_q) begin
            gnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            ptr_d   = owner_nxt;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      ptr_q   <= '0;
      tcl_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      ptr_q   <= ptr_d;
      tcl_q   <= tcl_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.owner = owner_q;
  assign bus.cnt   = cnt_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.abort = abort_q;

endmodule

// File: tb/tb_counter_rr_sched.sv
// Self-checking bench for counter_rr_sched: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_counter_rr_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int OWNW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  counter_rr_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH), .OWNW(OWNW)) bus_if ();

  counter_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .OWNW(OWNW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: who owns the counter, how far it has got, and where
  // the next round-robin search starts.
  bit m_running;
  int m_owner, m_cnt, m_tcl, m_ptr;
  bit m_done, m_abort;

  function automatic void model_reset();
    m_running = 0; m_owner = 0; m_cnt = 0; m_tcl = 0; m_ptr = 0;
    m_done = 0; m_abort = 0;
  endfunction

  function automatic void model_step(input logic [3:0] r, input logic [15:0] t, input logic e);
    m_done  = 0;
    m_abort = 0;
    if (!m_running) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (r[j]) begin
          m_owner   = j;
          m_tcl     = int'((t >> (4 * j)) & 16'hF);
          m_cnt     = 0;
          m_running = 1;
          break;
        end
      end
    end else if (!r[m_owner]) begin
      m_abort = 1; m_running = 0; m_cnt = 0; m_ptr = (m_owner + 1) % NREQ;
    end else if (e) begin
      if (m_cnt == m_tcl) begin
        m_done = 1; m_running = 0; m_ptr = (m_owner + 1) % NREQ;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string nm);
    chk({nm, ".gnt"},   32'(bus_if.gnt),   m_running ? (32'd1 << m_owner) : 32'd0);
    chk({nm, ".owner"}, 32'(bus_if.owner), 32'(m_owner));
    chk({nm, ".cnt"},   32'(bus_if.cnt),   32'(m_cnt));
    chk({nm, ".busy"},  32'(bus_if.busy),  32'(m_running));
    chk({nm, ".done"},  32'(bus_if.done),  32'(m_done));
    chk({nm, ".abort"}, 32'(bus_if.abort), 32'(m_abort));
  endtask

  // One clock: model consumes the inputs seen at this edge; sampling at negedge.
  task automatic tick();
    model_step(bus_if.req, bus_if.tc, bus_if.en);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus_if.req = '0; bus_if.tc = '0; bus_if.en = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [15:0] tc;
    logic        en;
    logic [3:0]  gnt;
    logic [3:0]  cnt;
    logic        busy;
    logic        done;
    logic        abort;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // Expected outputs are those seen after the edge that consumes the inputs.
    vecs[0] = '{4'b0001, 16'h0003, 1'b1, 4'b0001, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{4'b0001, 16'h0003, 1'b1, 4'b0001, 4'd1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{4'b0001, 16'h0003, 1'b1, 4'b0001, 4'd2, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{4'b0001, 16'h0003, 1'b1, 4'b0001, 4'd3, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{4'b0001, 16'h0003, 1'b1, 4'b0000, 4'd3, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{4'b0000, 16'h0003, 1'b1, 4'b0000, 4'd3, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{4'b0001, 16'h0003, 1'b1, 4'b0001, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{4'b0001, 16'h0003, 1'b0, 4'b0001, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{4'b0000, 16'h0003, 1'b1, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{4'b0000, 16'h0003, 1'b1, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0};

    do_reset();
    chk("reset.gnt",  32'(bus_if.gnt), 0);
    chk("reset.cnt",  32'(bus_if.cnt), 0);
    chk("reset.busy", 32'(bus_if.busy), 0);
    check_model("reset");

    // Vector table: single request, then a short run that is aborted.
    foreach (vecs[i]) begin
      bus_if.req = vecs[i].req; bus_if.tc = vecs[i].tc; bus_if.en = vecs[i].en;
      tick();
      chk($sformatf("vec%0d.gnt", i),   32'(bus_if.gnt),   32'(vecs[i].gnt));
      chk($sformatf("vec%0d.cnt", i),   32'(bus_if.cnt),   32'(vecs[i].cnt));
      chk($sformatf("vec%0d.busy", i),  32'(bus_if.busy),  32'(vecs[i].busy));
      chk($sformatf("vec%0d.done", i),  32'(bus_if.done),  32'(vecs[i].done));
      chk($sformatf("vec%0d.abort", i), 32'(bus_if.abort), 32'(vecs[i].abort));
    end

    // Fairness: all requesting, tc=1 each -> 2 grant cycles + 1 done cycle.
    do_reset();
    bus_if.req = 4'b1111; bus_if.tc = 16'h1111; bus_if.en = 1'b1;
    for (int k = 0; k < 15; k++) begin
      logic [3:0] eg;
      tick();
      eg = (k % 3 < 2) ? 4'(1 << ((k / 3) % 4)) : 4'b0000;
      chk($sformatf("fair%0d.gnt", k),  32'(bus_if.gnt),  32'(eg));
      chk($sformatf("fair%0d.done", k), 32'(bus_if.done), (k % 3 == 2) ? 1 : 0);
    end

    // Pause: en low for 3 cycles while cnt=2.
    do_reset();
    bus_if.req = 4'b0100; bus_if.tc = 16'h0500;
    begin
      logic       en_s [10] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
      int         ec   [10] = '{0, 1, 2, 2, 2, 2, 3, 4, 5, 5};
      for (int k = 0; k < 10; k++) begin
        bus_if.en = en_s[k];
        tick();
        chk($sformatf("pause%0d.cnt", k),  32'(bus_if.cnt),  32'(ec[k]));
        chk($sformatf("pause%0d.gnt", k),  32'(bus_if.gnt),  (k < 9) ? 32'h4 : 32'h0);
        chk($sformatf("pause%0d.done", k), 32'(bus_if.done), (k == 9) ? 1 : 0);
      end
    end

    // Abort: owner 1 drops req at cnt=2; next winner is 2 despite req0.
    do_reset();
    bus_if.req = 4'b0010; bus_if.tc = 16'h0070; bus_if.en = 1'b1;
    tick(); tick(); tick();
    chk("abort.pre_cnt", 32'(bus_if.cnt), 2);
    bus_if.req = 4'b0101;
    tick();
    chk("abort.pulse", 32'(bus_if.abort), 1);
    chk("abort.done",  32'(bus_if.done), 0);
    chk("abort.cnt",   32'(bus_if.cnt), 0);
    chk("abort.gnt",   32'(bus_if.gnt), 0);
    tick();
    chk("abort.next_gnt",   32'(bus_if.gnt), 32'b0100);
    chk("abort.next_owner", 32'(bus_if.owner), 2);
    chk("abort.pulse_gone", 32'(bus_if.abort), 0);

    // tc change during RUN is ignored.
    do_reset();
    bus_if.req = 4'b0001; bus_if.tc = 16'h0002; bus_if.en = 1'b1;
    tick();
    bus_if.tc = 16'h000F;
    tick(); tick(); tick();
    chk("tcchg.done", 32'(bus_if.done), 1);
    chk("tcchg.cnt",  32'(bus_if.cnt), 2);

    // tc = 0: one grant cycle then done.
    do_reset();
    bus_if.req = 4'b0001; bus_if.tc = 16'h0000; bus_if.en = 1'b1;
    tick();
    chk("tc0.gnt", 32'(bus_if.gnt), 1);
    tick();
    chk("tc0.done", 32'(bus_if.done), 1);
    chk("tc0.gnt_off", 32'(bus_if.gnt), 0);

    // tc = F: full count, no wrap.
    do_reset();
    bus_if.req = 4'b0001; bus_if.tc = 16'h000F; bus_if.en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("tcF%0d.cnt", k), 32'(bus_if.cnt), 32'(k));
      chk($sformatf("tcF%0d.gnt", k), 32'(bus_if.gnt), 1);
    end
    tick();
    chk("tcF.done", 32'(bus_if.done), 1);
    chk("tcF.cnt",  32'(bus_if.cnt), 15);

    // Reset mid-RUN: move ptr away from 0 first, then reset at cnt=6.
    do_reset();
    bus_if.req = 4'b0010; bus_if.tc = 16'h0000; bus_if.en = 1'b1;
    tick(); tick();
    chk("rst.first_done", 32'(bus_if.done), 1);
    bus_if.req = 4'b1000; bus_if.tc = 16'hF000;
    tick();
    chk("rst.gnt3", 32'(bus_if.gnt), 32'b1000);
    repeat (6) tick();
    chk("rst.cnt6", 32'(bus_if.cnt), 6);
    #2 rst = 1'b0;
    #1;
    chk("rst.async_gnt",  32'(bus_if.gnt), 0);
    chk("rst.async_cnt",  32'(bus_if.cnt), 0);
    chk("rst.async_busy", 32'(bus_if.busy), 0);
    chk("rst.async_done", 32'(bus_if.done), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    bus_if.req = 4'b1010;
    tick();
    chk("rst.regrant", 32'(bus_if.gnt), 32'b0010);

    // Randomized traffic against the model, with sticky requests.
    do_reset();
    begin
      logic [3:0]  r = '0;
      logic [15:0] t;
      for (int k = 0; k < 1500; k++) begin
        for (int b = 0; b < NREQ; b++)
          if ($urandom_range(0, 11) == 0) r[b] = ~r[b];
        t = 16'($urandom);
        if ($urandom_range(0, 3) != 0) t = t & 16'h3333;
        bus_if.req = r; bus_if.tc = t; bus_if.en = ($urandom_range(0, 3) != 0);
        tick();
        check_model("rand");
        chk("rand.excl", 32'(bus_if.done & bus_if.abort), 0);
        chk("rand.onehot", 32'($onehot0(bus_if.gnt)), 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
